key_debounce: RTL and testbench

- Input-side companion to the LED output driver: conditions one raw push-button signal into a clean, debounced level plus single-cycle event pulses.
- Output events drive LED patterns or mode changes elsewhere in the design.
- Handles metastability with a 2-flop synchronizer, filters contact bounce with a stability counter, and optionally detects a long press.

---
 rtl/key_debounce.sv | 131 +++++++++++++
 tb/tb_key_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, debouncer and press/release/long-press pulse generator
// Long-press detection is enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_e;

  logic          key_n;
  logic          sync1_q;
  logic          key_s_q;
  state_e        state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          mismatch;
  logic          accept;

  // Polarity is normalised before the synchronizer so every flop holds 1 = pressed.
  assign key_n = KEY_ACTIVE_LOW ? ~key_in : key_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
    end
  end

  assign mismatch = (key_s_q != (state_q == PRESSED));
  assign accept   = mismatch && (deb_cnt_q == DEB_LAST);

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any cycle where the synchronized level agrees with the accepted one restarts the count.
    if (mismatch && !accept) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state     = (state_q == PRESSED);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_q, long_d;

  // Saturating at LONG_CYCLES guarantees a single long pulse per hold.
  always_comb begin
    hold_cnt_d = '0;
    long_d     = 1'b0;
    if (state_q == PRESSED) begin
      long_d = (hold_cnt_q == HOLD_LAST);
      if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce (DEBOUNCE_CYCLES=20, LONG_CYCLES=100)
module tb_key_debounce;

  localparam int DEB  = 20;
  localparam int LONG = 100;
  localparam int LAT  = DEB + 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic key_in;
  logic key_state;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int  cyc;
  int  total;
  int  bad;
  ev_t exp_q[$];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the head of the queue.
  initial begin
    logic [2:0] p;
    ev_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_event kind=%0d expected_cycle=%0d now=%0d", exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      p = {long_pulse, release_pulse, press_pulse};
      if (press_pulse && release_pulse) begin
        total++;
        bad++;
        $display("FAIL both_pulses at cycle %0d: got press=1 release=1 expected at most one", cyc);
      end
      for (int k = 0; k < 3; k++) begin
        if (p[k]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d: expected no pulse", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
              bad++;
              $display("FAIL event_match got kind=%0d cycle=%0d expected kind=%0d cycle=%0d", k, cyc, e.kind, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst    = 1'b0;
    key_in = 1'b0;

    // Held in reset with the key pressed: nothing may come out.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_key_state", key_state, 1'b0);
      chk("rst_press", press_pulse, 1'b0);
      chk("rst_release", release_pulse, 1'b0);
      chk("rst_long", long_pulse, 1'b0);
    end
    rst = 1'b1;
    push_ev(0, cyc + LAT);
    step(LAT - 1);
    chk("rst_release_pre", key_state, 1'b0);
    step(1);
    chk("rst_release_post", key_state, 1'b1);
    key_in = 1'b1;
    push_ev(1, cyc + LAT);
    step(LAT);
    chk("first_release_state", key_state, 1'b0);

    // Clean press and release.
    key_in = 1'b0;
    push_ev(0, cyc + LAT);
    step(LAT - 1);
    chk("clean_press_pre", key_state, 1'b0);
    step(1);
    chk("clean_press_post", key_state, 1'b1);
    step(3);
    chk("clean_press_hold", key_state, 1'b1);
    key_in = 1'b1;
    push_ev(1, cyc + LAT);
    step(LAT - 1);
    chk("clean_release_pre", key_state, 1'b1);
    step(3);
    chk("clean_release_post", key_state, 1'b0);

    // Bounce, then settle and hold well past the long-press threshold.
    for (int i = 0; i < 12; i++) begin
      key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(5);
      chk("bounce_key_state", key_state, 1'b0);
    end
    key_in = 1'b0;
    c = cyc;
    push_ev(0, c + LAT);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    push_ev(2, c + LAT + LONG);
`endif
    step(LAT - 1);
    chk("bounce_press_pre", key_state, 1'b0);
    step(1);
    chk("bounce_press_post", key_state, 1'b1);
    step(150);
    chk("long_hold_state", key_state, 1'b1);
    key_in = 1'b1;
    push_ev(1, cyc + LAT);
    step(LAT + 3);
    chk("long_release_state", key_state, 1'b0);

    // Glitches of 15 and DEB-1 cycles are rejected; exactly DEB cycles is accepted.
    key_in = 1'b0;
    step(15);
    key_in = 1'b1;
    step(30);
    chk("glitch15_state", key_state, 1'b0);
    key_in = 1'b0;
    step(DEB - 1);
    key_in = 1'b1;
    step(30);
    chk("glitch19_state", key_state, 1'b0);
    key_in = 1'b0;
    c = cyc;
    push_ev(0, c + LAT);
    step(DEB);
    key_in = 1'b1;
    push_ev(1, cyc + LAT);
    step(2);
    chk("pulse20_state", key_state, 1'b1);
    step(LAT + 3);
    chk("pulse20_release", key_state, 1'b0);

    // Reset in the middle of a debounce count restarts it from zero.
    key_in = 1'b0;
    step(10);
    rst = 1'b0;
    step(3);
    chk("midrst_key_state", key_state, 1'b0);
    rst = 1'b1;
    push_ev(0, cyc + LAT);
    step(LAT);
    chk("midrst_press_state", key_state, 1'b1);
    key_in = 1'b1;
    push_ev(1, cyc + LAT);
    step(LAT + 3);
    chk("midrst_release_state", key_state, 1'b0);

    step(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
